dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbitrates two cores' MEM-stage data accesses onto the dual-port data memory: core 0 always drives port A, core 1 always drives port B. It serialises same-word conflicts with a round-robin priority bit and stalls the losing core. It also keeps per-core LL/SC reservations for inter-core atomics. It sits between the two core pipelines and `dmem`, which has combinational read and writes on the posedge.

## Interface
- `CNT_W`, default 16: width of the saturating conflict counter.

- `CLK` in 1: clock.
- `RST` in 1: synchronous reset, active-high.
- `MemReq0` / `MemReq1` in 1: core issues a memory access this cycle.
- `MemWrite0` / `MemWrite1` in 1: plain store (SW).
- `LinkedLoad0` / `LinkedLoad1` in 1: LL. Honoured only when MemWrite=0 and StoreCond=0.
- `StoreCond0` / `StoreCond1` in 1: SC. Implies a write; MemWrite is ignored when set.
- `Address0` / `Address1` in 32: byte address. Word index is [31:2].
- `WriteData0` / `WriteData1` in 32: store data.
- `ReadData0` / `ReadData1` out 32: load data, passed through from ReadDataA / ReadDataB.
- `Stall0` / `Stall1` out 1: request lost arbitration. Core must hold the request and retry.
- `ScSuccess0` / `ScSuccess1` out 1: granted SC succeeded and its write is performed this cycle.
- `WriteEnableA` / `WriteEnableB` out 1: to dmem.
- `AddressA` / `AddressB` out 32: to dmem. Always equal to Address0 / Address1.
- `WriteDataA` / `WriteDataB` out 32: to dmem. Always equal to WriteData0 / WriteData1.
- `ReadDataA` / `ReadDataB` in 32: from dmem.
- `ConflictCount` out CNT_W: number of conflict cycles, saturating.

## Operation
- Per core c: Wc = MemReq_c & (MemWrite_c | StoreCond_c). Rc = MemReq_c & !Wc.
- Conflict = MemReq0 & MemReq1 & (Address0[31:2] == Address1[31:2]) & (W0 | W1). A failed SC still counts as a write for conflict purposes. Two reads of the same word never conflict.
- Priority register `Prio` selects the winner on a conflict: 0 means core 0 wins.
  - After any conflict cycle, Prio is set to the losing core's index.
  - With no conflict, Prio holds.
- Granted: MemReq_c & !(Conflict & loser == c). Stall_c = MemReq_c & !Granted_c.
- Reservations: ResValid_c (1 bit) and ResAddr_c (30 bits) per core.
- SC outcome: ScSuccess_c = Granted_c & StoreCond_c & ResValid_c & (ResAddr_c == Address_c[31:2]).
- Write enable: WriteEnable{A,B}_c = Granted_c & ((MemWrite_c & !StoreCond_c) | ScSuccess_c). A failed SC never writes.
- Reservation updates at the posedge, in priority order:
  1. Any granted write to word X clears every reservation (both cores) whose ResAddr == X. This covers a plain SW and a successful SC.
  2. A granted SC clears its own reservation, whether it succeeded or failed.
  3. A granted LL on core c sets ResValid_c=1 and ResAddr_c=Address_c[31:2]. This overrides the clear from rule 1, which can only come from the same cycle's other-core write to a different word.
- ConflictCount increments on each conflict cycle and saturates at 2^CNT_W−1.
- RST=1 forces all outputs below to their reset values for that cycle. No writes reach dmem during reset.

## Timing
- Stall, ScSuccess, ReadData and dmem port signals are combinational in the same cycle as the request. They depend only on inputs and registered state.
- A dmem write commits at the posedge ending the granted cycle. A read in the next cycle sees the new data.
- A stalled core retries in the next cycle. Because Prio now favours it, it is granted within one cycle. Worst-case access latency is 2 cycles.
- Reset values: Prio=0; ResValid0=ResValid1=0; ResAddr=0; ConflictCount=0.
- Combinational outputs while RST=1: Stall=0, ScSuccess=0, WriteEnableA/B=0.
- Reset in the middle of a retry discards the pending stall. After reset core 0 has priority.
- Both cores writing the same word is always serialised, so dmem never sees simultaneous writes to one word.
- Different words, any mix of reads and writes: both cores are granted, no stall, ConflictCount unchanged.

## Test plan
- Core0 SW 0x10←0xAAAA and core1 SW 0x10←0x5555 in the same cycle, after reset:
  - Stall1=1, mem[4]=0xAAAA, Prio=1, ConflictCount=1.
  - Retry next cycle: Stall1=0, mem[4]=0x5555.
- Core0 LW 0x20 and core1 LW 0x20 in the same cycle → no stalls, both ReadData=mem[8], ConflictCount unchanged.
- Core0 LL 0x40, then core0 SC 0x40←7 two cycles later with no intervening write → ScSuccess0=1, mem[16]=7, ResValid0=0.
- Core0 LL 0x40, then core1 SW 0x40←9, then core0 SC 0x40←7 → ScSuccess0=0, mem[16] stays 9.
- Conflict every cycle for 3 cycles → winners alternate core0, core1, core0. ConflictCount=3. A CNT_W=2 variant saturates at 3.
- RST asserted while Stall1=1 and ResValid0=1 → WriteEnableA/B=0, ResValid cleared, Prio=0 on the following cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-core front end for the dual-port data memory: same-word conflict
// serialisation with round-robin priority, stall generation and LL/SC reservations.
module dmem_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,

  input  logic             MemReq0,
  input  logic             MemWrite0,
  input  logic             LinkedLoad0,
  input  logic             StoreCond0,
  input  logic [31:0]      Address0,
  input  logic [31:0]      WriteData0,
  output logic [31:0]      ReadData0,
  output logic             Stall0,
  output logic             ScSuccess0,

  input  logic             MemReq1,
  input  logic             MemWrite1,
  input  logic             LinkedLoad1,
  input  logic             StoreCond1,
  input  logic [31:0]      Address1,
  input  logic [31:0]      WriteData1,
  output logic [31:0]      ReadData1,
  output logic             Stall1,
  output logic             ScSuccess1,

  output logic             WriteEnableA,
  output logic [31:0]      AddressA,
  output logic [31:0]      WriteDataA,
  input  logic [31:0]      ReadDataA,

  output logic             WriteEnableB,
  output logic [31:0]      AddressB,
  output logic [31:0]      WriteDataB,
  input  logic [31:0]      ReadDataB,

  output logic [CNT_W-1:0] ConflictCount
);

  // Core c always owns dmem port c; data and address are pure pass-through.
  assign AddressA   = Address0;
  assign AddressB   = Address1;
  assign WriteDataA = WriteData0;
  assign WriteDataB = WriteData1;
  assign ReadData0  = ReadDataA;
  assign ReadData1  = ReadDataB;

  logic             req   [2];
  logic             mwr   [2];
  logic             llk   [2];
  logic             stc   [2];
  logic [29:0]      word  [2];

  assign req[0]  = MemReq0;      assign req[1]  = MemReq1;
  assign mwr[0]  = MemWrite0;    assign mwr[1]  = MemWrite1;
  assign llk[0]  = LinkedLoad0;  assign llk[1]  = LinkedLoad1;
  assign stc[0]  = StoreCond0;   assign stc[1]  = StoreCond1;
  assign word[0] = Address0[31:2];
  assign word[1] = Address1[31:2];

  // Registered state
  logic             prio;
  logic             res_valid [2];
  logic [29:0]      res_addr  [2];
  logic [CNT_W-1:0] conflict_cnt;

  // Next-state / per-core combinational terms
  logic             prio_nxt;
  logic             res_valid_nxt [2];
  logic [29:0]      res_addr_nxt  [2];
  logic             is_write [2];
  logic             grant    [2];
  logic             stall    [2];
  logic             sc_ok    [2];
  logic             wen      [2];
  logic             conflict;
  logic             loser;

  // A failed SC still counts as a write here, so it serialises like any store.
  assign is_write[0] = req[0] & (mwr[0] | stc[0]);
  assign is_write[1] = req[1] & (mwr[1] | stc[1]);
  assign conflict    = req[0] & req[1] & (word[0] == word[1]) &
                       (is_write[0] | is_write[1]);
  assign loser       = ~prio;

  // NOTE: every variable written in this block gets a default first, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    prio_nxt = prio;
    for (int c = 0; c < 2; c++) begin
      grant[c] = 1'b0;
      stall[c] = 1'b0;
      sc_ok[c] = 1'b0;
      wen[c]   = 1'b0;
    end

    // Reset suppresses every grant, so nothing stalls and nothing writes.
    if (!RST) begin
      for (int c = 0; c < 2; c++) begin
        grant[c] = req[c] & ~(conflict & (loser == c[0]));
        stall[c] = req[c] & ~grant[c];
        sc_ok[c] = grant[c] & stc[c] & res_valid[c] & (res_addr[c] == word[c]);
        wen[c]   = grant[c] & ((mwr[c] & ~stc[c]) | sc_ok[c]);
      end
      if (conflict)
        prio_nxt = loser;
    end

    for (int c = 0; c < 2; c++) begin
      res_valid_nxt[c] = res_valid[c];
      res_addr_nxt[c]  = res_addr[c];
      if ((wen[0] && word[0] == res_addr[c]) || (wen[1] && word[1] == res_addr[c]))
        res_valid_nxt[c] = 1'b0;
      if (grant[c] && stc[c])
        res_valid_nxt[c] = 1'b0;
      // A granted LL wins over a clear from the other core's write elsewhere.
      if (grant[c] && llk[c] && !mwr[c] && !stc[c]) begin
        res_valid_nxt[c] = 1'b1;
        res_addr_nxt[c]  = word[c];
      end
    end
  end

  assign Stall0       = stall[0];
  assign Stall1       = stall[1];
  assign ScSuccess0   = sc_ok[0];
  assign ScSuccess1   = sc_ok[1];
  assign WriteEnableA = wen[0];
  assign WriteEnableB = wen[1];
  assign ConflictCount = conflict_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prio         <= 1'b0;
      res_valid[0] <= 1'b0;
      res_valid[1] <= 1'b0;
      res_addr[0]  <= '0;
      res_addr[1]  <= '0;
      conflict_cnt <= '0;
    end else begin
      prio         <= prio_nxt;
      res_valid[0] <= res_valid_nxt[0];
      res_valid[1] <= res_valid_nxt[1];
      res_addr[0]  <= res_addr_nxt[0];
      res_addr[1]  <= res_addr_nxt[1];
      if (conflict && conflict_cnt != {CNT_W{1'b1}})
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural dual-port dmem and a
// second instance built with CNT_W=2 to exercise counter saturation.
module tb_dmem_arbiter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic        MemReq0, MemWrite0, LinkedLoad0, StoreCond0;
  logic        MemReq1, MemWrite1, LinkedLoad1, StoreCond1;
  logic [31:0] Address0, WriteData0, Address1, WriteData1;
  logic [31:0] ReadData0, ReadData1;
  logic        Stall0, Stall1, ScSuccess0, ScSuccess1;
  logic        WriteEnableA, WriteEnableB;
  logic [31:0] AddressA, AddressB, WriteDataA, WriteDataB;
  logic [31:0] ReadDataA, ReadDataB;
  logic [15:0] ConflictCount;

  logic [31:0] s_rd0, s_rd1, s_aa, s_ab, s_wda, s_wdb;
  logic        s_st0, s_st1, s_sc0, s_sc1, s_wea, s_web;
  logic [1:0]  s_cnt;

  int n_pass = 0;
  int n_total = 0;

  dmem_arbiter #(.CNT_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .MemReq0(MemReq0), .MemWrite0(MemWrite0), .LinkedLoad0(LinkedLoad0),
    .StoreCond0(StoreCond0), .Address0(Address0), .WriteData0(WriteData0),
    .ReadData0(ReadData0), .Stall0(Stall0), .ScSuccess0(ScSuccess0),
    .MemReq1(MemReq1), .MemWrite1(MemWrite1), .LinkedLoad1(LinkedLoad1),
    .StoreCond1(StoreCond1), .Address1(Address1), .WriteData1(WriteData1),
    .ReadData1(ReadData1), .Stall1(Stall1), .ScSuccess1(ScSuccess1),
    .WriteEnableA(WriteEnableA), .AddressA(AddressA), .WriteDataA(WriteDataA),
    .ReadDataA(ReadDataA),
    .WriteEnableB(WriteEnableB), .AddressB(AddressB), .WriteDataB(WriteDataB),
    .ReadDataB(ReadDataB),
    .ConflictCount(ConflictCount)
  );

  dmem_arbiter #(.CNT_W(2)) dut_small (
    .CLK(CLK), .RST(RST),
    .MemReq0(MemReq0), .MemWrite0(MemWrite0), .LinkedLoad0(LinkedLoad0),
    .StoreCond0(StoreCond0), .Address0(Address0), .WriteData0(WriteData0),
    .ReadData0(s_rd0), .Stall0(s_st0), .ScSuccess0(s_sc0),
    .MemReq1(MemReq1), .MemWrite1(MemWrite1), .LinkedLoad1(LinkedLoad1),
    .StoreCond1(StoreCond1), .Address1(Address1), .WriteData1(WriteData1),
    .ReadData1(s_rd1), .Stall1(s_st1), .ScSuccess1(s_sc1),
    .WriteEnableA(s_wea), .AddressA(s_aa), .WriteDataA(s_wda),
    .ReadDataA(ReadDataA),
    .WriteEnableB(s_web), .AddressB(s_ab), .WriteDataB(s_wdb),
    .ReadDataB(ReadDataB),
    .ConflictCount(s_cnt)
  );

  // Behavioural dmem: combinational read, posedge write, zeroed on first reset.
  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;
  assign ReadDataA = mem[AddressA[9:2]];
  assign ReadDataB = mem[AddressB[9:2]];

  always @(posedge CLK) begin
    if (RST && !mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem_init <= 1'b1;
    end else begin
      if (WriteEnableA) mem[AddressA[9:2]] <= WriteDataA;
      if (WriteEnableB) mem[AddressB[9:2]] <= WriteDataB;
    end
  end

  task automatic drive0(input logic req, input logic wr, input logic ll,
                        input logic sc, input logic [31:0] a, input logic [31:0] d);
    MemReq0 = req; MemWrite0 = wr; LinkedLoad0 = ll; StoreCond0 = sc;
    Address0 = a; WriteData0 = d;
  endtask

  task automatic drive1(input logic req, input logic wr, input logic ll,
                        input logic sc, input logic [31:0] a, input logic [31:0] d);
    MemReq1 = req; MemWrite1 = wr; LinkedLoad1 = ll; StoreCond1 = sc;
    Address1 = a; WriteData1 = d;
  endtask

  task automatic idle_both();
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1;
    drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'hDEAD);
    drive1(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'hBEEF);
    #1;
    n_total++; if ({Stall0, Stall1} !== 2'b00) $display("FAIL reset_stall got %b want 00", {Stall0, Stall1}); else n_pass++;
    n_total++; if ({WriteEnableA, WriteEnableB} !== 2'b00) $display("FAIL reset_we got %b want 00", {WriteEnableA, WriteEnableB}); else n_pass++;
    @(posedge CLK); @(negedge CLK); // second reset cycle: dmem model already zeroed
    #1;
    n_total++; if ({ScSuccess0, ScSuccess1} !== 2'b00) $display("FAIL reset_sc got %b want 00", {ScSuccess0, ScSuccess1}); else n_pass++;
    @(posedge CLK); #1;
    n_total++; if (ConflictCount !== 16'd0) $display("FAIL reset_count got %0d want 0", ConflictCount); else n_pass++;
    n_total++; if (mem[8'hC0] !== 32'h0) $display("FAIL reset_nowrite got %h want 0", mem[8'hC0]); else n_pass++;
    @(negedge CLK);
    RST = 1'b0;
    idle_both();
  endtask

  task automatic test_sw_conflict();
    @(negedge CLK);
    drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'hAAAA);
    drive1(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h5555);
    #1;
    n_total++; if ({Stall0, Stall1} !== 2'b01) $display("FAIL swc_stall got %b want 01", {Stall0, Stall1}); else n_pass++;
    n_total++; if ({WriteEnableA, WriteEnableB} !== 2'b10) $display("FAIL swc_we got %b want 10", {WriteEnableA, WriteEnableB}); else n_pass++;
    @(posedge CLK); #1;
    n_total++; if (mem[4] !== 32'hAAAA) $display("FAIL swc_mem got %h want aaaa", mem[4]); else n_pass++;
    n_total++; if (ConflictCount !== 16'd1) $display("FAIL swc_count got %0d want 1", ConflictCount); else n_pass++;
    @(negedge CLK);
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_total++; if ({Stall1, WriteEnableB} !== 2'b01) $display("FAIL swc_retry got %b want 01", {Stall1, WriteEnableB}); else n_pass++;
    @(posedge CLK); #1;
    n_total++; if (mem[4] !== 32'h5555) $display("FAIL swc_retry_mem got %h want 5555", mem[4]); else n_pass++;
    @(negedge CLK);
    idle_both();
  endtask

  task automatic test_read_same();
    drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h1234_5678);
    @(posedge CLK);
    @(negedge CLK);
    drive0(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
    drive1(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
    #1;
    n_total++; if ({Stall0, Stall1} !== 2'b00) $display("FAIL rd_same_stall got %b want 00", {Stall0, Stall1}); else n_pass++;
    n_total++; if (ReadData0 !== 32'h1234_5678) $display("FAIL rd_same_rd0 got %h want 12345678", ReadData0); else n_pass++;
    n_total++; if (ReadData1 !== 32'h1234_5678) $display("FAIL rd_same_rd1 got %h want 12345678", ReadData1); else n_pass++;
    @(posedge CLK); #1;
    n_total++; if (ConflictCount !== 16'd1) $display("FAIL rd_same_count got %0d want 1", ConflictCount); else n_pass++;
    @(negedge CLK);
    idle_both();
  endtask

  task automatic test_diff_words();
    @(negedge CLK);
    drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'hBEEF);
    drive1(1'b1, 1'b1, 1'b0, 1'b0, 32'h104, 32'hCAFE);
    #1;
    n_total++; if ({Stall0, Stall1, WriteEnableA, WriteEnableB} !== 4'b0011) $display("FAIL diff_ctl got %b want 0011", {Stall0, Stall1, WriteEnableA, WriteEnableB}); else n_pass++;
    @(posedge CLK); #1;
    n_total++; if ({mem[64], mem[65]} !== {32'hBEEF, 32'hCAFE}) $display("FAIL diff_mem got %h %h want beef cafe", mem[64], mem[65]); else n_pass++;
    n_total++; if (ConflictCount !== 16'd1) $display("FAIL diff_count got %0d want 1", ConflictCount); else n_pass++;
    @(negedge CLK);
    idle_both();
  endtask

  task automatic test_ll_sc();
    @(negedge CLK);
    drive0(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    @(posedge CLK); @(negedge CLK);
    idle_both();
    @(posedge CLK); @(negedge CLK);
    drive0(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'd7);
    #1;
    n_total++; if ({ScSuccess0, WriteEnableA} !== 2'b11) $display("FAIL llsc_ok got %b want 11", {ScSuccess0, WriteEnableA}); else n_pass++;
    @(posedge CLK); #1;
    n_total++; if (mem[16] !== 32'd7) $display("FAIL llsc_mem got %h want 7", mem[16]); else n_pass++;
    @(negedge CLK);
    drive0(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'd8);
    #1;
    n_total++; if ({ScSuccess0, WriteEnableA} !== 2'b00) $display("FAIL llsc_cleared got %b want 00", {ScSuccess0, WriteEnableA}); else n_pass++;
    @(posedge CLK); #1;
    n_total++; if (mem[16] !== 32'd7) $display("FAIL llsc_mem2 got %h want 7", mem[16]); else n_pass++;
    @(negedge CLK);
    idle_both();
  endtask

  task automatic test_ll_sw_sc();
    @(negedge CLK);
    drive0(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    @(posedge CLK); @(negedge CLK);
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'd9);
    @(posedge CLK); @(negedge CLK);
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive0(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'd7);
    #1;
    n_total++; if ({ScSuccess0, WriteEnableA} !== 2'b00) $display("FAIL llswsc_fail got %b want 00", {ScSuccess0, WriteEnableA}); else n_pass++;
    @(posedge CLK); #1;
    n_total++; if (mem[16] !== 32'd9) $display("FAIL llswsc_mem got %h want 9", mem[16]); else n_pass++;
    @(negedge CLK);
    idle_both();
  endtask

  // Priority is 1 here (core 1 lost the earlier SW conflict), so core 0 loses.
  task automatic test_failed_sc_conflict();
    @(negedge CLK);
    drive0(1'b1, 1'b0, 1'b0, 1'b1, 32'h60, 32'h77);
    drive1(1'b1, 1'b0, 1'b0, 1'b0, 32'h60, 32'h0);
    #1;
    n_total++; if ({Stall0, Stall1, ScSuccess0} !== 3'b100) $display("FAIL fsc_ctl got %b want 100", {Stall0, Stall1, ScSuccess0}); else n_pass++;
    @(posedge CLK); #1;
    n_total++; if (ConflictCount !== 16'd2) $display("FAIL fsc_count got %0d want 2", ConflictCount); else n_pass++;
    @(negedge CLK);
    idle_both();
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'h100 + i);
      drive1(1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'h200 + i);
      want = (i % 2 == 0) ? 32'h100 + i : 32'h200 + i;
      #1;
      n_total++; if ({Stall0, Stall1} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) $display("FAIL b2b_stall[%0d] got %b", i, {Stall0, Stall1}); else n_pass++;
      @(posedge CLK); #1;
      n_total++; if (mem[32] !== want) $display("FAIL b2b_mem[%0d] got %h want %h", i, mem[32], want); else n_pass++;
      n_total++; if (ConflictCount !== 16'(i + 1)) $display("FAIL b2b_count[%0d] got %0d want %0d", i, ConflictCount, i + 1); else n_pass++;
      n_total++; if (s_cnt !== ((i < 3) ? 2'(i + 1) : 2'd3)) $display("FAIL b2b_sat[%0d] got %0d", i, s_cnt); else n_pass++;
      @(negedge CLK);
    end
    idle_both();
  endtask

  // Priority is 0 entering this test, so the SW conflict stalls core 1.
  task automatic test_reset_mid_retry();
    @(negedge CLK);
    drive0(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    @(posedge CLK); @(negedge CLK);
    drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h11);
    drive1(1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h22);
    #1;
    n_total++; if (Stall1 !== 1'b1) $display("FAIL rmr_pre_stall got %b want 1", Stall1); else n_pass++;
    RST = 1'b1;
    #1;
    n_total++; if ({Stall0, Stall1, WriteEnableA, WriteEnableB} !== 4'b0000) $display("FAIL rmr_rst_ctl got %b want 0000", {Stall0, Stall1, WriteEnableA, WriteEnableB}); else n_pass++;
    @(posedge CLK); #1;
    n_total++; if (mem[128] !== 32'h0) $display("FAIL rmr_nowrite got %h want 0", mem[128]); else n_pass++;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    n_total++; if ({Stall0, Stall1} !== 2'b01) $display("FAIL rmr_prio got %b want 01", {Stall0, Stall1}); else n_pass++;
    @(posedge CLK); #1;
    n_total++; if (mem[128] !== 32'h11) $display("FAIL rmr_mem got %h want 11", mem[128]); else n_pass++;
    @(negedge CLK);
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive0(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'd5);
    #1;
    n_total++; if ({ScSuccess0, WriteEnableA} !== 2'b00) $display("FAIL rmr_res_cleared got %b want 00", {ScSuccess0, WriteEnableA}); else n_pass++;
    @(posedge CLK); @(negedge CLK);
    idle_both();
  endtask

  initial begin
    RST = 1'b1;
    idle_both();
    test_reset();
    test_sw_conflict();
    test_read_same();
    test_diff_words();
    test_ll_sc();
    test_ll_sw_sc();
    test_failed_sc_conflict();
    test_back_to_back();
    test_reset_mid_retry();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
